// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and limits for the priority scan encoder.
// Scan direction is chosen at build time by PSE_MSB_FIRST_EN (see pse_find_first).
package priority_scan_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } pse_state_e;

endpackage

// File: rtl/priority_scan_encoder_find_first.sv
// Combinational find-first-set over an N-bit vector; returns 0 for an all-zero vector.
// PSE_MSB_FIRST_EN defined: highest set index wins; undefined: lowest set index wins.
module pse_find_first #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx
);

    always_comb begin
        idx = '0;
`ifdef PSE_MSB_FIRST_EN
        // Ascending walk: the last match, the highest set bit, is kept.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
`else
        // Descending walk: the last match, the lowest set bit, is kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
`endif
    end

endmodule

// File: rtl/priority_scan_encoder.sv
// Accepts a request vector, then emits the index of each set bit one beat at a time.
// Scan order is set by PSE_MSB_FIRST_EN (MSB first when defined, LSB first otherwise).
module priority_scan_encoder
    import priority_scan_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         last,
    output logic         zero,
    output pse_state_e   state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // valid and ready come only from registered state, never from the partner's signal,
    // so no input reaches an output combinationally.

    pse_state_e   state_q;
    pse_state_e   state_d;
    logic [N-1:0] s_q;
    logic         zero_q;
    logic [W-1:0] ff_idx;
    logic         single;
    logic         accept;
    logic         take;

    pse_find_first #(.N(N), .W(W)) u_find_first (
        .vec (s_q),
        .idx (ff_idx)
    );

    // True for zero or one remaining set bit: the current beat is the final one.
    assign single = (s_q & (s_q - N'(1))) == '0;
    assign accept = (state_q == IDLE) && in_valid;
    assign take   = (state_q == SCAN) && out_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        y         = '0;
        last      = 1'b0;
        zero      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SCAN;
            end
            SCAN: begin
                out_valid = 1'b1;
                y         = ff_idx;
                last      = single;
                zero      = zero_q;
                if (out_ready && single) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                s_q    <= d;
                zero_q <= (d == '0);
            end else if (take) begin
                s_q[ff_idx] <= 1'b0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: N=8 and N=16 instances against a bit-list reference model.
// Follows PSE_MSB_FIRST_EN for the expected scan order.
module tb_priority_scan_encoder;
    import priority_scan_pkg::*;

    localparam int BUDGET = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        sel;         // 0 drives the N=8 instance, 1 drives the N=16 instance
    logic        in_valid;
    logic [15:0] d;
    logic        out_ready;

    logic        in_ready8, out_valid8, last8, zero8;
    logic [2:0]  y8;
    pse_state_e  state8;
    logic        in_ready16, out_valid16, last16, zero16;
    logic [3:0]  y16;
    pse_state_e  state16;

    priority_scan_encoder #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && !sel),
        .in_ready  (in_ready8),
        .d         (d[7:0]),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .y         (y8),
        .last      (last8),
        .zero      (zero8),
        .state     (state8)
    );

    priority_scan_encoder #(.N(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && sel),
        .in_ready  (in_ready16),
        .d         (d),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .y         (y16),
        .last      (last16),
        .zero      (zero16),
        .state     (state16)
    );

    logic       o_in_ready, o_out_valid, o_last, o_zero;
    logic [3:0] o_y;
    assign o_in_ready  = sel ? in_ready16  : in_ready8;
    assign o_out_valid = sel ? out_valid16 : out_valid8;
    assign o_last      = sel ? last16      : last8;
    assign o_zero      = sel ? zero16      : zero8;
    assign o_y         = sel ? y16         : {1'b0, y8};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];   // {y[3:0], last, zero}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: list the set bits of v in scan order; final entry carries last.
    task automatic build_exp(input logic [15:0] v, input int n);
        int idx[$];
        for (int i = 0; i < n; i++) if (v[i]) idx.push_back(i);
`ifdef PSE_MSB_FIRST_EN
        idx.reverse();
`endif
        if (idx.size() == 0) begin
            exp_q.push_back({4'd0, 1'b1, 1'b1});
        end else begin
            foreach (idx[k])
                exp_q.push_back({4'(idx[k]), 1'(k == idx.size() - 1), 1'b0});
        end
    endtask

    // ---------------- driver ----------------
    // mode 0: out_ready always 1; 1: random out_ready; 2: out_ready 0 for first 3 cycles.
    task automatic run_vec(input logic which, input logic [15:0] v, input int mode,
                           input logic hold_valid, input logic [15:0] hold_d);
        int cyc;
        int n;
        logic [5:0] e;
        n = which ? 16 : 8;
        sel = which;
        check("in_ready_before_accept", 32'(o_in_ready), 32'd1);
        in_valid = 1'b1;
        d = v;
        @(posedge clk); #1;
        build_exp(v, n);
        if (hold_valid) d = hold_d;
        else in_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < BUDGET) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 2) != 0);
                default: out_ready = (cyc >= 3);
            endcase
            e = exp_q[0];
            check("out_valid_scan", 32'(o_out_valid), 32'd1);
            check("in_ready_scan", 32'(o_in_ready), 32'd0);
            check("y", 32'(o_y), 32'(e[5:2]));
            check("last", 32'(o_last), 32'(e[1]));
            check("zero", 32'(o_zero), 32'(e[0]));
            if (out_ready) void'(exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            check("beat_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        out_ready = 1'b0;
        check("out_valid_bubble", 32'(o_out_valid), 32'd0);
        check("in_ready_bubble", 32'(o_in_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sel = 1'b0;
        in_valid = 1'b0;
        d = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready8), 32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_y", 32'(y8), 32'd0);
        check("rst_last", 32'(last8), 32'd0);
        check("rst_zero", 32'(zero8), 32'd0);
        check("rst_state", 32'(state8), 32'(IDLE));
        rst = 1'b0;

        // Directed cases
        run_vec(1'b0, 16'h00A4, 0, 1'b0, 16'h0);
        run_vec(1'b0, 16'h0000, 0, 1'b0, 16'h0);
        run_vec(1'b0, 16'h0081, 2, 1'b0, 16'h0);
        // in_valid held with new data throughout the scan; accepted once IDLE returns
        run_vec(1'b0, 16'h00FF, 0, 1'b1, 16'h0001);
        run_vec(1'b0, 16'h0001, 0, 1'b0, 16'h0);
        run_vec(1'b1, 16'h8001, 0, 1'b0, 16'h0);
        run_vec(1'b1, 16'h0000, 1, 1'b0, 16'h0);

        // Reset in the middle of a scan abandons the remaining bits
        sel = 1'b0;
        in_valid = 1'b1;
        d = 16'h000F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_state_scan", 32'(state8), 32'(SCAN));
        @(posedge clk); #1;   // first beat taken, second beat now presented
        check("mid_rst_second_valid", 32'(out_valid8), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid8), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready8), 32'd1);
        check("mid_rst_y", 32'(y8), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("mid_rst_no_beats", 32'(out_valid8), 32'd0);
        end
        out_ready = 1'b0;

        // Randomized vectors on both widths
        for (int t = 0; t < 30; t++) begin
            logic [15:0] v;
            v = 16'($urandom());
            if ($urandom_range(0, 7) == 0) v = '0;
            if (t % 3 == 2) run_vec(1'b1, v, int'($urandom_range(0, 1)), 1'b0, 16'h0);
            else run_vec(1'b0, {8'h00, v[7:0]}, int'($urandom_range(0, 1)), 1'b0, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/priority_scan_encoder.md
PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 Parameter N, default 8, meaning input vector width; legal range 2..256.
REQ-002 Derived localparam W = $clog2(N), meaning index width; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  d is presented for acceptance.
REQ-006 in_ready  output  1  block can accept d this cycle.
REQ-007 d  input  N  one-hot or multi-hot request vector.
REQ-008 out_valid  output  1  y/last/zero hold a valid beat.
REQ-009 out_ready  input  1  consumer accepts current beat.
REQ-010 y  output  W  bit index of current set bit.
REQ-011 last  output  1  current beat is final beat for the accepted vector.
REQ-012 zero  output  1  accepted vector was all zeros.

Function
REQ-013 Two states SHALL exist: IDLE and SCAN.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid&&in_ready SHALL latch d into shadow register s and go to SCAN next cycle.
REQ-015 SCAN: in_ready=0, out_valid=1; in_valid SHALL be ignored, with no effect on s.
REQ-016 y SHALL equal index of first set bit in s in scan order; latency accept->first out_valid = 1 cycle.
REQ-017 last SHALL be 1 when s has exactly one set bit, or when s==0.
REQ-018 On out_valid&&out_ready, the bit at y SHALL be cleared in s; if last=1, state returns to IDLE next cycle.
REQ-019 Without handshake, y/last/zero SHALL hold stable while out_valid=1.
REQ-020 Accepted d==0 SHALL produce exactly one beat with y=0, zero=1, last=1.
REQ-021 zero SHALL be 0 for any nonzero accepted vector.
REQ-022 Throughput: one index per cycle under continuous out_ready; one IDLE bubble cycle between vectors.
REQ-023 No combinational path from out_ready or in_valid to any output.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, s=0, out_valid=0, y=0, last=0, zero=0, in_ready=1 on the following cycle.
REQ-025 rst mid-SCAN SHALL abandon remaining bits; no further beats for that vector.

Configuration
REQ-026 Macro PSE_MSB_FIRST_EN defined: scan order SHALL be MSB to LSB (highest index first).
REQ-027 Macro PSE_MSB_FIRST_EN undefined: scan order SHALL be LSB to MSB (lowest index first).

Structure
REQ-028 Package priority_scan_pkg SHALL hold the state enum type (IDLE, SCAN) and the N range-limit constants.
REQ-029 Combinational find-first-set SHALL be one sub-module, pse_find_first, parametrised by N with order selected by the macro.

Verification
REQ-030 N=8, d=8'b1010_0100, out_ready=1: LSB-first -> y=2,5,7 with last on 7; MSB-first -> y=7,5,2 with last on 2; in_ready=1 the cycle after last.
REQ-031 N=8, d=8'h00: exactly one beat, y=0, zero=1, last=1; then IDLE.
REQ-032 N=8, d=8'h81, out_ready=0 for 3 cycles then 1: y held at first index for 4 cycles, second beat follows, last on second.
REQ-033 N=8, d=8'hFF, in_valid held 1 with d=8'h01 throughout: 8 beats y=0..7 (LSB-first), in_ready=0 during SCAN, then 8'h01 accepted after IDLE.
REQ-034 rst pulsed on the 2nd beat of d=8'h0F: next cycle out_valid=0, in_ready=1, y=0; no further beats.
REQ-035 N=16, d=16'h8001: W=4, LSB-first -> y=0 then y=15 with last=1.
